// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types and helpers for the multi-port register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Width of the initialisation counter; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Value loaded into register idx during initialisation.
    function automatic logic [31:0] init_value(input logic [31:0] idx, input int mode);
        return (mode == 0) ? idx : 32'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_init_seq.sv
// ============================================================================
//  Module      : regfile_init_seq
//  Description : Post-reset sequencer that walks every register once.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 15,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy_o,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o
);

    localparam int                 c_CNT_W = cnt_width(NUM_REGS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(NUM_REGS - 1);

    state_e             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + c_CNT_W'(1);
            if (cnt_q == c_LAST) begin
                state_d = ST_READY;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        end
    end

    // The write strobe is gated by rst so a reset edge never loads a stale index.
    assign init_we_o   = (state_q == ST_INIT) && rst;
    assign init_addr_o = ADDR_W'(cnt_q);
    assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module      : regfile_mp
//  Description : Parametrised 2-write / N-read register file with bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int NUM_REGS  = 15,
    parameter int NUM_RD    = 3,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam logic [ADDR_W:0] c_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              wr_drop_q, wr_drop_d;
    logic              w_busy;
    logic              w_init_we;
    logic [ADDR_W-1:0] w_init_addr;
    logic              w_wr0_ok, w_wr1_ok;

    regfile_init_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .busy_o      (w_busy),
        .init_we_o   (w_init_we),
        .init_addr_o (w_init_addr)
    );

    assign w_wr0_ok  = wr0_en && !w_busy && ({1'b0, wr0_addr} < c_NUM_REGS);
    assign w_wr1_ok  = wr1_en && !w_busy && ({1'b0, wr1_addr} < c_NUM_REGS);
    assign wr_drop_d = (wr0_en && !w_wr0_ok) || (wr1_en && !w_wr1_ok);

    // Port 1 is written last so it wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (w_init_we) begin
            mem_q[w_init_addr] <= DATA_W'(init_value(32'(w_init_addr), INIT_MODE));
        end else begin
            if (w_wr0_ok) mem_q[wr0_addr] <= wr0_data;
            if (w_wr1_ok) mem_q[wr1_addr] <= wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) wr_drop_q <= 1'b0;
        else      wr_drop_q <= wr_drop_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = '0;
            if (!w_busy && ({1'b0, w_addr} < c_NUM_REGS)) begin
                w_data = mem_q[w_addr];
                if (BYPASS != 0) begin
                    if (w_wr1_ok && (wr1_addr == w_addr))      w_data = wr1_data;
                    else if (w_wr0_ok && (wr0_addr == w_addr)) w_data = wr0_data;
                end
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = w_data;
    end

    assign busy    = w_busy;
    assign wr_drop = wr_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Scoreboard bench for regfile_mp (bypass/mode-0 and no-bypass/mode-1 copies).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 15;
    localparam int RD = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr0_en, wr1_en;
    logic [AW-1:0]    wr0_addr, wr1_addr;
    logic [DW-1:0]    wr0_data, wr1_data;
    logic [RD*AW-1:0] rd_addr;
    logic [RD*DW-1:0] rd_data_a, rd_data_b;
    logic             busy_a, busy_b, drop_a, drop_b;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(RD),
                 .BYPASS(1), .INIT_MODE(0)) u_dut_a (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(rd_data_a), .busy(busy_a), .wr_drop(drop_a)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(RD),
                 .BYPASS(0), .INIT_MODE(1)) u_dut_b (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(rd_data_b), .busy(busy_b), .wr_drop(drop_b)
    );

    typedef struct packed {
        logic             busy;
        logic             drop;
        logic [RD*DW-1:0] rd_a;
        logic [RD*DW-1:0] rd_b;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: a countdown of remaining init cycles plus two plain arrays.
    int          busy_left;
    logic        m_drop;
    logic [31:0] m_a [16];
    logic [31:0] m_b [16];

    function automatic logic [DW-1:0] exp_rd(input bit byp, input bit inst_b, input int a);
        if (busy_left > 0 || a >= NR) return '0;
        if (byp && wr1_en && int'(wr1_addr) == a && int'(wr1_addr) < NR) return wr1_data;
        if (byp && wr0_en && int'(wr0_addr) == a && int'(wr0_addr) < NR) return wr0_data;
        return inst_b ? m_b[a] : m_a[a];
    endfunction

    task automatic push_expected();
        exp_t e;
        e.busy = (busy_left > 0);
        e.drop = m_drop;
        for (int k = 0; k < RD; k++) begin
            e.rd_a[k*DW +: DW] = exp_rd(1'b1, 1'b0, int'(rd_addr[k*AW +: AW]));
            e.rd_b[k*DW +: DW] = exp_rd(1'b0, 1'b1, int'(rd_addr[k*AW +: AW]));
        end
        sb.push_back(e);
    endtask

    task automatic model_update();
        if (!rst) begin
            if (busy_left == 0) begin
                if (wr0_en && wr0_addr < NR) begin m_a[wr0_addr] = wr0_data; m_b[wr0_addr] = wr0_data; end
                if (wr1_en && wr1_addr < NR) begin m_a[wr1_addr] = wr1_data; m_b[wr1_addr] = wr1_data; end
            end
            busy_left = NR;
            m_drop    = 1'b0;
        end else if (busy_left > 0) begin
            m_drop    = wr0_en || wr1_en;
            busy_left = busy_left - 1;
            if (busy_left == 0) begin
                for (int i = 0; i < NR; i++) begin
                    m_a[i] = 32'(i);
                    m_b[i] = 32'd0;
                end
            end
        end else begin
            m_drop = (wr0_en && wr0_addr >= NR) || (wr1_en && wr1_addr >= NR);
            if (wr0_en && wr0_addr < NR) begin m_a[wr0_addr] = wr0_data; m_b[wr0_addr] = wr0_data; end
            if (wr1_en && wr1_addr < NR) begin m_a[wr1_addr] = wr1_data; m_b[wr1_addr] = wr1_data; end
        end
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Monitor: the register file presents fresh outputs every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("busy_a", DW'(busy_a), DW'(e.busy));
            chk("busy_b", DW'(busy_b), DW'(e.busy));
            chk("drop_a", DW'(drop_a), DW'(e.drop));
            chk("drop_b", DW'(drop_b), DW'(e.drop));
            for (int k = 0; k < RD; k++) begin
                chk($sformatf("rd_a[%0d]", k), rd_data_a[k*DW +: DW], e.rd_a[k*DW +: DW]);
                chk($sformatf("rd_b[%0d]", k), rd_data_b[k*DW +: DW], e.rd_b[k*DW +: DW]);
            end
        end
    end

    task automatic step(input logic r,
                        input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic [RD*AW-1:0] ra);
        rst = r;
        wr0_en = e0; wr0_addr = a0; wr0_data = d0;
        wr1_en = e1; wr1_addr = a1; wr1_data = d1;
        rd_addr = ra;
        push_expected();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_read(input logic r, input logic [RD*AW-1:0] ra);
        step(r, 1'b0, '0, '0, 1'b0, '0, '0, ra);
    endtask

    initial begin
        int wait_cyc;
        rst = 1'b0;
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        rd_addr = {4'd14, 4'd7, 4'd3};
        for (int i = 0; i < 16; i++) begin m_a[i] = 'x; m_b[i] = 'x; end
        @(posedge clk);
        busy_left = NR;
        m_drop    = 1'b0;
        #1;
        idle_read(1'b0, {4'd14, 4'd7, 4'd3});

        // Initialisation, with a few writes attempted while busy.
        for (int i = 0; i < NR; i++) begin
            if (i % 4 == 1) step(1'b1, 1'b1, 4'(i), 32'hBAD0_0000, 1'b0, '0, '0, {4'd14, 4'd7, 4'd3});
            else            idle_read(1'b1, {4'd14, 4'd7, 4'd3});
        end
        idle_read(1'b1, {4'd14, 4'd7, 4'd3});
        idle_read(1'b1, {4'd0, 4'd1, 4'd13});

        // Dual write, same-address conflict, bypass, illegal address.
        step(1'b1, 1'b1, 4'd2, 32'hAAAA_0000, 1'b1, 4'd5, 32'h5555_FFFF, {4'd2, 4'd5, 4'd0});
        idle_read(1'b1, {4'd0, 4'd5, 4'd2});
        step(1'b1, 1'b1, 4'd4, 32'h11, 1'b1, 4'd4, 32'h22, {4'd4, 4'd4, 4'd4});
        idle_read(1'b1, {4'd4, 4'd3, 4'd4});
        step(1'b1, 1'b0, '0, '0, 1'b1, 4'd9, 32'hDEAD_BEEF, {4'd8, 4'd10, 4'd9});
        idle_read(1'b1, {4'd8, 4'd10, 4'd9});
        step(1'b1, 1'b1, 4'd15, 32'h1234_5678, 1'b0, '0, '0, {4'd15, 4'd14, 4'd15});
        idle_read(1'b1, {4'd15, 4'd14, 4'd13});
        idle_read(1'b1, {4'd15, 4'd14, 4'd13});

        // Reset in the middle of initialisation restarts the full sequence.
        idle_read(1'b0, {4'd3, 4'd2, 4'd1});
        for (int i = 0; i < 6; i++) idle_read(1'b1, {4'd3, 4'd2, 4'd1});
        idle_read(1'b0, {4'd3, 4'd2, 4'd1});
        for (int i = 0; i < NR + 2; i++) idle_read(1'b1, {4'(i % 16), 4'd2, 4'd4});

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0),
                 1'($urandom), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom), 4'($urandom_range(0, 15)), $urandom,
                 {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))});
        end

        // Settle and sweep every address.
        for (int i = 0; i < NR + 2; i++) idle_read(1'b1, {4'd0, 4'd0, 4'd0});
        for (int i = 0; i < 16; i++) idle_read(1'b1, {4'(15 - i), 4'(i), 4'(i)});

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, dual-read ARM pipeline register file.
- Sits between the ID stage (read ports) and the WB stage (write ports).
- Adds configurable width, depth and read-port count, a second write port, optional write-to-read bypass, and a multi-cycle post-reset initialisation sequencer with a busy flag.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width
- NUM_REGS, 15, implemented registers; must satisfy NUM_REGS <= 2**ADDR_W
- NUM_RD, 3, number of read ports
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads see stored contents only
- INIT_MODE, 0, 0 = register i initialises to value i; 1 = all registers initialise to 0

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-low
- wr0_en  in  1  write port 0 enable
- wr0_addr  in  ADDR_W  write port 0 address
- wr0_data  in  DATA_W  write port 0 data
- wr1_en  in  1  write port 1 enable; has priority over port 0
- wr1_addr  in  ADDR_W  write port 1 address
- wr1_data  in  DATA_W  write port 1 data
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W]
- busy  out  1  high while initialisation is in progress
- wr_drop  out  1  registered one-cycle pulse: a write request was discarded in the previous cycle

Behaviour:
- Clocking: one clock, clk; rst is synchronous and active-low; no negedge logic.
- Reset (rst=0 sampled at a rising edge):
  - state <= INIT, init_cnt <= 0, busy <= 1, wr_drop <= 0.
  - Array contents are not cleared by reset itself.
- State INIT:
  - Each cycle with rst=1: reg[init_cnt] <= init value (init_cnt or 0, per INIT_MODE); init_cnt++.
  - When init_cnt == NUM_REGS-1 is written: state <= READY, busy <= 0 on that same edge.
  - Initialisation therefore takes exactly NUM_REGS cycles after rst rises.
- Reset asserted mid-INIT: sequencer restarts from init_cnt=0.
- State READY: normal operation; stays in READY until rst=0.
- Writes (READY only):
  - Each port with wr*_en=1 and address < NUM_REGS updates that register at the rising edge.
  - Both ports enabled with the same address: only port 1 data is stored.
  - Different addresses: both registers are written in the same cycle.
- Dropped writes:
  - A write with address >= NUM_REGS is ignored.
  - Any enabled write while busy=1 is ignored.
  - wr_drop=1 on the following cycle for either case; otherwise wr_drop=0.
- Reads (combinational, zero latency):
  - busy=1 -> every rd_data lane reads 0.
  - Address >= NUM_REGS -> lane reads 0.
  - Otherwise, with BYPASS=1, the lane returns the first match in this priority order:
    1. wr1_data, if wr1_en and wr1_addr == address
    2. wr0_data, if wr0_en and wr0_addr == address
    3. the stored value
  - Otherwise, with BYPASS=0, the lane returns the stored value.
  - Bypass applies only to writes that are legal this cycle: READY and address in range.
- Reads are independent across ports; any number of ports may read the same address.
- Widths: no arithmetic; addresses are compared as unsigned.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum (INIT, READY)
  - the init_value function (index or 0, selected by INIT_MODE)
  - a helper computing the init_cnt width, $clog2(NUM_REGS)
- One natural sub-module, regfile_init_seq: owns state, init_cnt and busy, and drives the init write strobe and address into the array.
- Read-mux and bypass logic are generated per port inside regfile_mp.

Test Plan:
1. Init, INIT_MODE=0: hold rst=0 for 2 cycles, then release -> busy=1 for exactly 15 cycles and all reads return 0; afterwards rd_addr lanes {3,7,14} read {3,7,14}.
2. Dual write, same cycle: wr0 (addr 2, 0xAAAA0000) and wr1 (addr 5, 0x5555FFFF) -> next cycle reg2=0xAAAA0000 and reg5=0x5555FFFF.
3. Same-address conflict: wr0 and wr1 both addr 4 with 0x11 and 0x22 -> reg4=0x22, wr_drop=0.
4. Bypass, BYPASS=1: wr1 to addr 9 with 0xDEADBEEF while rd lane 0 addresses 9 -> rd_data lane 0 = 0xDEADBEEF in the same cycle. Repeat with BYPASS=0 -> lane shows the old value 9, then 0xDEADBEEF next cycle.
5. Illegal writes:
   - wr0 to addr 15 in READY -> no register changes; wr_drop=1 for one cycle; a read of addr 15 returns 0.
   - Write during INIT -> dropped; wr_drop=1.
6. Reset mid-INIT: pull rst=0 at init_cnt=6, release -> busy stays high for a full 15 fresh cycles; final contents equal the init values.
